// File: rtl/move_collector.sv
// move_collector: drains per-square move FIFOs round-robin into one ready/valid move stream.
// Define MOVE_COUNT_EN to build the saturating accepted-move counter on mv_count.
module move_collector #(
   parameter int NUNITS = 64,
   parameter int WORD_W = 160
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUNITS-1:0]        done_in,
   input  logic [NUNITS-1:0]        fifo_empty,
   input  logic [NUNITS*WORD_W-1:0] fifo_data,
   output logic [NUNITS-1:0]        rden,
   output logic [18:0]              mv_out,
   output logic                     mv_valid,
   input  logic                     mv_ready,
   output logic                     all_done,
   output logic [9:0]               mv_count
);
   localparam int PW = (NUNITS > 1) ? $clog2(NUNITS) : 1;
   localparam int CW = $clog2(NUNITS + 1);
   typedef enum logic [2:0] {WAIT, SCAN, READ, LATCH, UNPACK, FIN} state_t;
   state_t            state_q;
   logic [PW-1:0]     ptr_q;
   logic [CW-1:0]     run_q;
   logic [151:0]      word_q;
   logic [2:0]        slot_q;
   logic [NUNITS-1:0] rden_q;
   logic [18:0]       mv_out_q;
   logic              mv_valid_q;
   logic              all_done_q;
   logic [PW-1:0]     ptr_nx;
   logic [18:0]       cur;
   logic              adv;
   assign ptr_nx = (ptr_q == PW'(NUNITS - 1)) ? '0 : ptr_q + 1'b1;
   assign cur    = word_q[19*slot_q +: 19];
   // a slot is finished either by its handshake or, when flagged invalid, immediately
   assign adv    = mv_valid_q ? mv_ready : cur[18];
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= WAIT;
         ptr_q      <= '0;
         run_q      <= '0;
         word_q     <= '0;
         slot_q     <= '0;
         rden_q     <= '0;
         mv_out_q   <= '0;
         mv_valid_q <= 1'b0;
         all_done_q <= 1'b0;
      end else begin
         case (state_q)
            WAIT: if (&done_in) begin
               state_q <= SCAN;
               ptr_q   <= '0;
               run_q   <= '0;
            end
            SCAN: if (!fifo_empty[ptr_q]) begin
               state_q <= READ;
               rden_q  <= NUNITS'(1) << ptr_q;
            end else begin
               ptr_q <= ptr_nx;
               run_q <= run_q + 1'b1;
               if (run_q == CW'(NUNITS - 1)) begin
                  state_q    <= FIN;
                  all_done_q <= 1'b1;
               end
            end
            READ: begin
               rden_q  <= '0;
               run_q   <= '0;
               state_q <= LATCH;
            end
            LATCH: begin
               word_q  <= fifo_data[ptr_q*WORD_W +: 152];
               slot_q  <= 3'd7;
               state_q <= UNPACK;
            end
            UNPACK: begin
               if (!mv_valid_q && !cur[18]) begin
                  mv_out_q   <= cur;
                  mv_valid_q <= 1'b1;
               end
               if (mv_valid_q && mv_ready) mv_valid_q <= 1'b0;
               if (adv) begin
                  slot_q <= slot_q - 1'b1;
                  if (slot_q == 3'd0) begin
                     state_q <= SCAN;
                     ptr_q   <= ptr_nx;
                  end
               end
            end
            default: begin
               rden_q     <= '0;
               mv_valid_q <= 1'b0;
               all_done_q <= 1'b1;
            end
         endcase
      end
   end
   assign rden     = rden_q;
   assign mv_out   = mv_out_q;
   assign mv_valid = mv_valid_q;
   assign all_done = all_done_q;
`ifdef MOVE_COUNT_EN
   logic [9:0] cnt_q;
   always_ff @(posedge clk)
      cnt_q <= reset ? '0 : (mv_valid_q && mv_ready && cnt_q != 10'h3ff) ? cnt_q + 1'b1 : cnt_q;
   assign mv_count = cnt_q;
`else
   assign mv_count = '0;
`endif
endmodule

// File: tb/tb_move_collector.sv
// tb_move_collector: randomized FIFO contents and mv_ready, scoreboard of expected moves per round-robin order.
module tb_move_collector;
   localparam int N = 4;
   localparam int W = 160;
   logic           clk = 1'b0;
   logic           reset;
   logic [N-1:0]   done_in, fifo_empty, rden;
   logic [N*W-1:0] fifo_data;
   logic [18:0]    mv_out;
   logic           mv_valid, mv_ready, all_done;
   logic [9:0]     mv_count;
   logic [W-1:0]   fq[N][$];
   logic [18:0]    exp_q[$];
   logic [18:0]    hold_out;
   int             vec = 0, miss = 0, hs = 0;
   bit             mon_en = 1'b0, hold = 1'b0;
   always #5 clk = ~clk;
   move_collector #(.NUNITS(N), .WORD_W(W)) dut (
      .clk(clk), .reset(reset), .done_in(done_in), .fifo_empty(fifo_empty),
      .fifo_data(fifo_data), .rden(rden), .mv_out(mv_out), .mv_valid(mv_valid),
      .mv_ready(mv_ready), .all_done(all_done), .mv_count(mv_count)
   );
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vec++;
      if (act !== req) begin
         miss++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask
   function automatic logic [31:0] cnt_exp(input int n);
`ifdef MOVE_COUNT_EN
      return (n > 1023) ? 1023 : n;
`else
      return (n > 0) ? 0 : 0;
`endif
   endfunction
   // FIFO model: q appears the cycle after rden, empty flag tracks the queue
   task automatic tick();
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (rden[i]) begin
            if (fq[i].size() == 0) begin
               vec++;
               miss++;
               $display("FAIL rd_empty: unit %0d read while empty", i);
            end else fifo_data[i*W +: W] = fq[i].pop_front();
         end
         fifo_empty[i] = (fq[i].size() == 0);
      end
   endtask
   always @(negedge clk) begin
      if (!mon_en) hold = 1'b0;
      else begin
         if (hold) begin
            check("hold_valid", 32'(mv_valid), 1);
            check("hold_out", 32'(mv_out), 32'(hold_out));
         end
         if (mv_valid && mv_ready) begin
            hs++;
            if (exp_q.size() == 0) begin
               vec++;
               miss++;
               $display("FAIL extra_move: got %0h expected none", mv_out);
            end else check("move", 32'(mv_out), 32'(exp_q.pop_front()));
         end
         hold = mv_valid && !mv_ready;
         hold_out = mv_out;
      end
   end
   function automatic logic [W-1:0] gen_word(input logic [7:0] m);
      logic [W-1:0] w;
      w = {$urandom, $urandom, $urandom, $urandom, $urandom};
      for (int s = 0; s < 8; s++) w[19*s +: 19] = {~m[s], 18'($urandom)};
      return w;
   endfunction
   // reference: visit non-empty units in circular order from the unit after the last one drained
   function automatic void build_exp();
      logic [W-1:0] m[N][$];
      logic [W-1:0] w;
      int p = 0, left = 0;
      for (int i = 0; i < N; i++) begin
         m[i] = fq[i];
         left += fq[i].size();
      end
      while (left > 0) begin
         for (int k = 0; k < N; k++) begin
            int u = (p + k) % N;
            if (m[u].size() != 0) begin
               w = m[u].pop_front();
               for (int s = 7; s >= 0; s--) if (!w[19*s+18]) exp_q.push_back(w[19*s +: 19]);
               p = (u + 1) % N;
               left--;
               break;
            end
         end
      end
   endfunction
   task automatic do_reset();
      mon_en = 1'b0;
      reset = 1'b1;
      done_in = '0;
      mv_ready = 1'b0;
      for (int i = 0; i < N; i++) fq[i].delete();
      exp_q.delete();
      fifo_data = '0;
      tick();
      tick();
      check("rst_rden", 32'(rden), 0);
      check("rst_mv_out", 32'(mv_out), 0);
      check("rst_mv_valid", 32'(mv_valid), 0);
      check("rst_all_done", 32'(all_done), 0);
      check("rst_mv_count", 32'(mv_count), 0);
      reset = 1'b0;
      hs = 0;
      mon_en = 1'b1;
   endtask
   // mode 0: random ready, 1: always ready, 3: ready withheld for the first 5 valid cycles
   task automatic run_test(input int mode, output int n, output int vc, output int rc, output int cy);
      build_exp();
      n = exp_q.size();
      vc = 0;
      rc = 0;
      cy = 0;
      mv_ready = (mode == 1);
      done_in = '1;
      while (!all_done && cy < 3000) begin
         tick();
         cy++;
         if (mv_valid) vc++;
         rc += $countones(rden);
         mv_ready = (mode == 0) ? 1'($urandom_range(0, 1)) : (mode == 1) ? 1'b1 : (vc >= 6);
      end
      if (!all_done) begin
         vec++;
         miss++;
         $display("FAIL timeout: all_done=%0b required 1", all_done);
      end
      tick();
   endtask
   task automatic finish_run(input int n);
      check("leftover", 32'(exp_q.size()), 0);
      check("handshakes", 32'(hs), 32'(n));
      check("mv_count", 32'(mv_count), cnt_exp(n));
      check("end_valid", 32'(mv_valid), 0);
      check("end_rden", 32'(rden), 0);
      check("end_all_done", 32'(all_done), 1);
   endtask
   initial begin
      int n, vc, rc, cy;
      logic [W-1:0] w;
      reset = 1'b1;
      done_in = '0;
      fifo_empty = '1;
      fifo_data = '0;
      mv_ready = 1'b0;
      do_reset();
      run_test(1, n, vc, rc, cy);
      check("empty_done_latency_ok", 32'(cy <= 6), 1);
      check("empty_rden_pulses", 32'(rc), 0);
      finish_run(n);
      for (int mode = 1; mode <= 3; mode += 2) begin
         do_reset();
         w = gen_word(8'h00);
         w[7*19 +: 19] = 19'h00012;
         fq[2].push_back(w);
         run_test(mode, n, vc, rc, cy);
         check("single_rden_pulses", 32'(rc), 1);
         check("single_valid_cycles", 32'(vc), (mode == 1) ? 1 : 6);
         finish_run(n);
      end
      do_reset();
      fq[0].push_back(gen_word(8'b1010_0100));
      fq[3].push_back(gen_word(8'b0011_0001));
      run_test(0, n, vc, rc, cy);
      check("two_unit_moves", 32'(hs), 6);
      finish_run(n);
      for (int r = 0; r < 10; r++) begin
         do_reset();
         for (int u = 0; u < N; u++) repeat ($urandom_range(0, 2)) fq[u].push_back(gen_word(8'($urandom)));
         run_test(0, n, vc, rc, cy);
         finish_run(n);
      end
      do_reset();
      fq[1].push_back(gen_word(8'hFF));
      build_exp();
      done_in = '1;
      mv_ready = 1'b1;
      cy = 0;
      while (!(mv_valid && hs >= 2) && cy < 200) begin
         tick();
         cy++;
      end
      check("mid_reached", 32'(mv_valid && hs >= 2), 1);
      check("mid_count", 32'(mv_count), cnt_exp(hs));
      mon_en = 1'b0;
      reset = 1'b1;
      done_in = '0;
      tick();
      reset = 1'b0;
      check("mid_rst_valid", 32'(mv_valid), 0);
      check("mid_rst_count", 32'(mv_count), 0);
      check("mid_rst_rden", 32'(rden), 0);
      check("mid_rst_all_done", 32'(all_done), 0);
      repeat (3) tick();
      check("wait_valid", 32'(mv_valid), 0);
      check("wait_rden", 32'(rden), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end
endmodule
